// File: rtl/mmio_req_decoder.sv
// MMIO request decoder: turns host MMIO writes into indexed user write strobes,
// answers the DFH/AFU_ID CSRs locally, and forwards user-window reads over a
// req/ack handshake with a bounded wait before issuing one read response.
module mmio_req_decoder #(
  parameter logic [15:0]  USER_BASE = 16'h0020,
  parameter int unsigned  USER_REGS = 8,
  parameter int unsigned  TIMEOUT   = 64,
  parameter logic [127:0] AFU_ID    = 128'h0,
  parameter int unsigned  IDX_W     = (USER_REGS > 1) ? $clog2(USER_REGS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mmio_wr_valid,
  input  logic             mmio_rd_valid,
  input  logic [15:0]      mmio_addr,
  input  logic [8:0]       mmio_tid,
  input  logic [63:0]      mmio_wdata,
  output logic             usr_wr_en,
  output logic [IDX_W-1:0] usr_wr_idx,
  output logic [63:0]      usr_wr_data,
  output logic             usr_rd_req,
  output logic [IDX_W-1:0] usr_rd_idx,
  input  logic             usr_rd_ack,
  input  logic [63:0]      usr_rd_data,
  output logic             rsp_valid,
  output logic [8:0]       rsp_tid,
  output logic [63:0]      rsp_data,
  output logic [15:0]      rd_drop_cnt,
  output logic [15:0]      timeout_cnt
);

  localparam int unsigned  CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [16:0]  USER_LO  = 17'(USER_BASE);
  localparam logic [16:0]  USER_HI  = 17'(USER_BASE) + 17'(2 * (USER_REGS - 1));
  localparam logic [63:0]  DFH_VAL  = 64'h1000_0100_0000_0000;
  localparam logic [63:0]  TOUT_VAL = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [15:0]  SAT_MAX  = 16'hFFFF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             wr_en_q, wr_en_d;
  logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
  logic [63:0]      wr_data_q, wr_data_d;
  logic             rd_req_q, rd_req_d;
  logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
  logic [8:0]       pend_tid_q, pend_tid_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [8:0]       rsp_tid_q, rsp_tid_d;
  logic [63:0]      rsp_data_q, rsp_data_d;
  logic [15:0]      drop_cnt_q, drop_cnt_d;
  logic [15:0]      tout_cnt_q, tout_cnt_d;

  logic [16:0]      addr_ext_c;
  logic [16:0]      addr_off_c;
  logic             in_win_c;
  logic [IDX_W-1:0] win_idx_c;
  logic [63:0]      csr_data_c;

  // User-window decode and local CSR read mux for the current request address
  always_comb begin
    addr_ext_c = {1'b0, mmio_addr};
    addr_off_c = addr_ext_c - USER_LO;
    in_win_c   = (addr_ext_c >= USER_LO) && (addr_ext_c <= USER_HI) && !addr_off_c[0];
    win_idx_c  = IDX_W'(addr_off_c[16:1]);
    case (mmio_addr)
      16'h0000: csr_data_c = DFH_VAL;
      16'h0002: csr_data_c = AFU_ID[63:0];
      16'h0004: csr_data_c = AFU_ID[127:64];
      default:  csr_data_c = 64'h0;
    endcase
  end

  // Next-state: write strobe path, read FSM, response capture and counters
  always_comb begin
    state_d     = state_q;
    wr_en_d     = 1'b0;
    wr_idx_d    = wr_idx_q;
    wr_data_d   = wr_data_q;
    rd_req_d    = rd_req_q;
    rd_idx_d    = rd_idx_q;
    pend_tid_d  = pend_tid_q;
    wait_cnt_d  = wait_cnt_q;
    rsp_valid_d = 1'b0;
    rsp_tid_d   = rsp_tid_q;
    rsp_data_d  = rsp_data_q;
    drop_cnt_d  = drop_cnt_q;
    tout_cnt_d  = tout_cnt_q;

    // Writes never interact with the read FSM
    if (mmio_wr_valid && in_win_c) begin
      wr_en_d   = 1'b1;
      wr_idx_d  = win_idx_c;
      wr_data_d = mmio_wdata;
    end

    // Only one read may be outstanding; extras are counted and discarded
    if (mmio_rd_valid && (state_q != S_IDLE) && (drop_cnt_q != SAT_MAX)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (mmio_rd_valid) begin
          if (in_win_c) begin
            state_d    = S_WAIT;
            rd_req_d   = 1'b1;
            rd_idx_d   = win_idx_c;
            pend_tid_d = mmio_tid;
            wait_cnt_d = '0;
          end else begin
            rsp_valid_d = 1'b1;
            rsp_tid_d   = mmio_tid;
            rsp_data_d  = csr_data_c;
          end
        end
      end
      S_WAIT: begin
        if (usr_rd_ack) begin
          state_d     = S_RESP;
          rd_req_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_tid_d   = pend_tid_q;
          rsp_data_d  = usr_rd_data;
        end else if (wait_cnt_q == CNT_LAST) begin
          state_d     = S_RESP;
          rd_req_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_tid_d   = pend_tid_q;
          rsp_data_d  = TOUT_VAL;
          if (tout_cnt_q != SAT_MAX) begin
            tout_cnt_d = tout_cnt_q + 16'd1;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d  = S_IDLE;
        rd_req_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any outstanding read silently
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wr_en_q     <= 1'b0;
      wr_idx_q    <= '0;
      wr_data_q   <= '0;
      rd_req_q    <= 1'b0;
      rd_idx_q    <= '0;
      pend_tid_q  <= '0;
      wait_cnt_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_tid_q   <= '0;
      rsp_data_q  <= '0;
      drop_cnt_q  <= '0;
      tout_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      wr_en_q     <= wr_en_d;
      wr_idx_q    <= wr_idx_d;
      wr_data_q   <= wr_data_d;
      rd_req_q    <= rd_req_d;
      rd_idx_q    <= rd_idx_d;
      pend_tid_q  <= pend_tid_d;
      wait_cnt_q  <= wait_cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_tid_q   <= rsp_tid_d;
      rsp_data_q  <= rsp_data_d;
      drop_cnt_q  <= drop_cnt_d;
      tout_cnt_q  <= tout_cnt_d;
    end
  end

  assign usr_wr_en   = wr_en_q;
  assign usr_wr_idx  = wr_idx_q;
  assign usr_wr_data = wr_data_q;
  assign usr_rd_req  = rd_req_q;
  assign usr_rd_idx  = rd_idx_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_tid     = rsp_tid_q;
  assign rsp_data    = rsp_data_q;
  assign rd_drop_cnt = drop_cnt_q;
  assign timeout_cnt = tout_cnt_q;

endmodule

// File: doc/mmio_req_decoder.md
Name: mmio_req_decoder

Overview:
- Front-end MMIO decode stage between the CCI-P c0 MMIO request fields and the AFU user datapath (user FIFO/register bank).
- Turns host MMIO writes into single-cycle indexed write strobes.
- Serves the mandatory DFH/AFU_ID read CSRs locally.
- Forwards user-window reads over a req/ack handshake with timeout, then emits one registered MMIO read response (tid + data) for the c2 response path.

Parameters:
- USER_BASE, 16'h0020, DW address of user register 0.
- USER_REGS, 8, number of 64-bit user registers; register i is at USER_BASE+2*i.
- TIMEOUT, 64, maximum cycles spent waiting for usr_rd_ack (must be >=1).
- AFU_ID, 128'h0, value returned at 0x0002 (low half) and 0x0004 (high half).
- IDX_W, max(1,$clog2(USER_REGS)), user index width (derived).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- mmio_wr_valid  in  1  MMIO write request this cycle
- mmio_rd_valid  in  1  MMIO read request this cycle
- mmio_addr  in  16  DW address of request
- mmio_tid  in  9  read transaction ID
- mmio_wdata  in  64  write data
- usr_wr_en  out  1  one-cycle user write strobe
- usr_wr_idx  out  IDX_W  user register index for write
- usr_wr_data  out  64  user write data
- usr_rd_req  out  1  user read request (level)
- usr_rd_idx  out  IDX_W  user register index for read
- usr_rd_ack  in  1  user read data valid
- usr_rd_data  in  64  user read data
- rsp_valid  out  1  one-cycle MMIO read response valid
- rsp_tid  out  9  response transaction ID
- rsp_data  out  64  response data
- rd_drop_cnt  out  16  saturating count of reads dropped while busy
- timeout_cnt  out  16  saturating count of user read timeouts

Behaviour:
- Interface: reset rst, asynchronous, active-high; clock clk.
- Reset: all outputs 0, internal counters 0, FSM in IDLE. Reset asserted mid-transaction aborts it; no response is ever issued for the aborted read.
- User window: addr in [USER_BASE, USER_BASE+2*(USER_REGS-1)] with (addr-USER_BASE) even. Index is (addr-USER_BASE)>>1.
- Write path, independent of the read FSM:
  - mmio_wr_valid with a user-window address -> next cycle usr_wr_en=1 with registered idx/data.
  - Any other address, including odd or DFH addresses, is ignored.
  - usr_wr_en stays 0 on every other cycle.
  - Back-to-back writes produce back-to-back strobes.
- Read FSM states: IDLE, WAIT_USR, RESP.
- IDLE, on mmio_rd_valid: capture tid.
  - addr 0x0000: respond with 64'h1000_0100_0000_0000 (feature type AFU, end-of-list).
  - addr 0x0002: respond AFU_ID[63:0].
  - addr 0x0004: respond AFU_ID[127:64].
  - addr 0x0006, 0x0008, and any unmapped address: respond 0.
  - All of the above assert rsp_valid on the next cycle (latency 1) and the FSM stays in IDLE.
  - User-window address: go to WAIT_USR; next cycle usr_rd_req=1 with usr_rd_idx; wait counter cleared.
- WAIT_USR:
  - usr_rd_req held high.
  - usr_rd_ack=1 -> latch usr_rd_data, go to RESP.
  - Otherwise the counter increments; if no ack arrives in the TIMEOUT-th WAIT_USR cycle, latch 64'hFFFF_FFFF_FFFF_FFFF, increment timeout_cnt, go to RESP.
  - Ack in the same cycle as expiry: ack wins and timeout_cnt is not incremented.
  - Ack outside WAIT_USR is ignored.
- RESP: rsp_valid=1 for exactly one cycle with the captured tid/data; usr_rd_req=0; return to IDLE.
- Read latency: rd at cycle 0, ack in cycle k -> rsp_valid at cycle k+1. Timeout -> rsp_valid at cycle TIMEOUT+1.
- mmio_rd_valid while in WAIT_USR or RESP: request dropped, rd_drop_cnt +1 (saturates at 0xFFFF), no response.
- Simultaneous write and read in the same cycle: both are processed. A write to the register being read does not alter the pending read.
- rsp_tid/rsp_data hold their last values when rsp_valid=0.

Test Plan:
- Write addr 0x0024, data 0xA5 -> one cycle later usr_wr_en=1, usr_wr_idx=2, usr_wr_data=0xA5. Write 0x0021 -> no strobe.
- Read addr 0x0000, tid 0x1F3 -> next cycle rsp_valid=1, tid 0x1F3, data 0x1000010000000000. Read 0x0002 -> AFU_ID[63:0]. Read 0x0040 -> data 0.
- Read 0x0022, tid 5; usr_rd_req high with idx 1; ack in 3rd WAIT cycle with data 0x1234 -> rsp_valid one cycle later, tid 5, data 0x1234, then IDLE.
- TIMEOUT=8, read 0x0020, never ack -> rsp_valid at cycle 9, data all ones, timeout_cnt=1. Repeat with ack in WAIT cycle 8 -> ack data returned, timeout_cnt unchanged.
- Read 0x0020 with no ack, then second read 0x0000 during WAIT_USR -> rd_drop_cnt=1, only the first read is answered. Write 0x0026 during WAIT_USR -> strobe idx 3 still issued.
- Read 0x0020, assert rst in WAIT_USR cycle 2 -> all outputs 0 and no rsp_valid after release. Next read 0x0004 answered normally.
